// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI-to-SRAM slave: AXI channel widths, SRAM
// control encodings and the controller state type.
package axi_sram_pkg;

  localparam int AXI_ID_W   = 8;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 4;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_RESP_W = 2;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY = 2'b00;
  localparam logic [AXI_STRB_W-1:0] WEB_NONE  = '1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_e;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4 slave fronting a single-port 32-bit SRAM; one burst in flight, INCR
// bursts of 4-byte beats, word address wraps within the SRAM.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int          ADDR_WORDS_BITS = 14,
  parameter logic [31:0] BASE_ADDR       = 32'h0001_0000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [AXI_ID_W-1:0]        awid,
  input  logic [AXI_ADDR_W-1:0]      awaddr,
  input  logic [AXI_LEN_W-1:0]       awlen,
  input  logic [2:0]                 awsize,
  input  logic [1:0]                 awburst,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [AXI_DATA_W-1:0]      wdata,
  input  logic [AXI_STRB_W-1:0]      wstrb,
  input  logic                       wlast,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [AXI_ID_W-1:0]        bid,
  output logic [AXI_RESP_W-1:0]      bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [AXI_ID_W-1:0]        arid,
  input  logic [AXI_ADDR_W-1:0]      araddr,
  input  logic [AXI_LEN_W-1:0]       arlen,
  input  logic [2:0]                 arsize,
  input  logic [1:0]                 arburst,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [AXI_ID_W-1:0]        rid,
  output logic [AXI_DATA_W-1:0]      rdata,
  output logic [AXI_RESP_W-1:0]      rresp,
  output logic                       rlast,
  output logic                       rvalid,
  input  logic                       rready,
  output logic                       sram_cs,
  output logic                       sram_oe,
  output logic [AXI_STRB_W-1:0]      sram_web,
  output logic [ADDR_WORDS_BITS-1:0] sram_a,
  output logic [AXI_DATA_W-1:0]      sram_di,
  input  logic [AXI_DATA_W-1:0]      sram_do
);

  state_e                     state, state_nx;
  logic [AXI_ID_W-1:0]        id_q;
  logic [ADDR_WORDS_BITS-1:0] addr_q;
  logic [AXI_LEN_W-1:0]       len_q;
  logic [AXI_LEN_W-1:0]       cnt_q;
  logic [AXI_DATA_W-1:0]      rdata_p1;
  logic                       last_beat;
  logic                       unused_attr;

  // Size and burst type carry no information for this slave.
  assign unused_attr = ^{awsize, awburst, arsize, arburst};

  function automatic logic [ADDR_WORDS_BITS-1:0] word_addr(input logic [AXI_ADDR_W-1:0] byte_addr);
    logic [AXI_ADDR_W-1:0] off;
    off = byte_addr - BASE_ADDR;
    return ADDR_WORDS_BITS'(off >> 2);
  endfunction

  assign last_beat = (cnt_q == len_q);
  assign bid       = id_q;
  assign rid       = id_q;
  assign bresp     = RESP_OKAY;
  assign rresp     = RESP_OKAY;
  assign rdata     = rdata_p1;

  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    arready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    rvalid   = 1'b0;
    rlast    = 1'b0;
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = WEB_NONE;
    sram_a   = '0;
    sram_di  = '0;
    case (state)
      IDLE: begin
        // Readies are gated by rstn so no handshake is signalled while reset is held.
        awready = rstn;
        arready = rstn && !awvalid;
        if (rstn && awvalid)      state_nx = WR_DATA;
        else if (rstn && arvalid) state_nx = RD_ADDR;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_cs  = 1'b1;
          sram_web = ~wstrb;
          sram_a   = addr_q;
          sram_di  = wdata;
          if (wlast) state_nx = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_nx = IDLE;
      end
      RD_ADDR: begin
        sram_cs  = 1'b1;
        sram_oe  = 1'b1;
        sram_a   = addr_q;
        state_nx = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        rlast  = last_beat;
        if (rready) state_nx = last_beat ? IDLE : RD_ADDR;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rdata_p1 <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (awvalid) begin
            id_q   <= awid;
            addr_q <= word_addr(awaddr);
            len_q  <= awlen;
            cnt_q  <= '0;
          end else if (arvalid) begin
            id_q   <= arid;
            addr_q <= word_addr(araddr);
            len_q  <= arlen;
            cnt_q  <= '0;
          end
        end
        WR_DATA: if (wvalid) addr_q <= addr_q + ADDR_WORDS_BITS'(1);
        // SRAM data is available by the closing edge of the cs+oe cycle.
        RD_ADDR: rdata_p1 <= sram_do;
        RD_DATA: begin
          if (rready && !last_beat) begin
            addr_q <= addr_q + ADDR_WORDS_BITS'(1);
            cnt_q  <= cnt_q + AXI_LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized scoreboard bench for axi_sram_slave with a word-array reference
// model and a behavioural SRAM on the SRAM port.
`timescale 1ns/1ps
module tb_axi_sram_slave;

  localparam int          AWB   = 14;
  localparam int          DEPTH = 1 << AWB;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata, sram_di, sram_do;
  logic [3:0] awlen = '0, arlen = '0, wstrb = '0, sram_web;
  logic [2:0] awsize = 3'd2, arsize = 3'd2;
  logic [1:0] awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 1;
  logic arvalid = 0, arready, rlast, rvalid, rready = 1, sram_cs, sram_oe;
  logic [AWB-1:0] sram_a;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_WORDS_BITS(AWB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    for (int b = 0; b < 4; b++) if (strb[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  // Behavioural SRAM: write on the clock edge, read data presented while cs+oe.
  logic [31:0] sram_mem [DEPTH];
  always @(posedge clk)
    if (sram_cs && !sram_oe) sram_mem[sram_a] <= merge(sram_mem[sram_a], sram_di, ~sram_web);
  assign sram_do = (sram_cs && sram_oe) ? sram_mem[sram_a] : 32'h0;

  // Reference model and scoreboard queues.
  typedef struct { logic [7:0] id; logic [31:0] data; logic last; } rexp_t;
  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  b_q[$];
  rexp_t       r_q[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: pops expectations on every handshake and watches hold rules.
  int cyc = 0, ar_cyc = -1, b_cyc = -1, r_seen = 0, n_rstall = 0;
  int r_cyc_log[$];
  bit first_r_pend = 0, r_stall = 0, b_stall = 0;
  logic [31:0] r_hold, last_rdata = '0;
  logic r_last_hold;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (r_stall) begin
        chk("r_hold_valid", 32'(rvalid), 32'd1);
        chk("r_hold_data", rdata, r_hold);
        chk("r_hold_last", 32'(rlast), 32'(r_last_hold));
      end
      if (b_stall) chk("b_hold_valid", 32'(bvalid), 32'd1);
      if (rvalid && first_r_pend) begin
        chk("r_first_latency", 32'(cyc - ar_cyc), 32'd2);
        first_r_pend = 0;
      end
      if (arvalid && arready) begin
        ar_cyc = cyc;
        first_r_pend = 1;
      end
      if (bvalid && bready) begin
        b_cyc = cyc;
        if (b_q.size() == 0) fail("b_unexpected");
        else begin
          chk("bid", 32'(bid), 32'(b_q.pop_front()));
          chk("bresp", 32'(bresp), 32'd0);
        end
      end
      if (rvalid && rready) begin
        r_seen++;
        r_cyc_log.push_back(cyc);
        last_rdata = rdata;
        if (r_q.size() == 0) fail("r_unexpected");
        else begin
          rexp_t e;
          e = r_q.pop_front();
          chk("rid", 32'(rid), 32'(e.id));
          chk("rdata", rdata, e.data);
          chk("rlast", 32'(rlast), 32'(e.last));
          chk("rresp", 32'(rresp), 32'd0);
        end
      end
      r_stall     = rvalid && !rready;
      r_hold      = rdata;
      r_last_hold = rlast;
      if (r_stall) n_rstall++;
      b_stall = bvalid && !bready;
    end else begin
      r_stall = 0;
      b_stall = 0;
      first_r_pend = 0;
    end
  end

  // Optional random backpressure on B and R.
  bit bp_en = 0;
  always @(posedge clk) if (bp_en) begin
    #1;
    rready = ($urandom_range(0, 3) != 0);
    bready = ($urandom_range(0, 3) != 0);
  end

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
  endfunction

  // Drivers: every task starts and ends 1ns after a rising edge.
  task automatic aw_send(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len);
    int n = 0; bit hs;
    awid = id; awaddr = a; awlen = len; awvalid = 1;
    do begin @(negedge clk); hs = awready; @(posedge clk); #1; n++; end while (!hs && n < 300);
    awvalid = 0;
    if (!hs) fail("aw_timeout");
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len);
    int n = 0; bit hs;
    arid = id; araddr = a; arlen = len; arvalid = 1;
    do begin @(negedge clk); hs = arready; @(posedge clk); #1; n++; end while (!hs && n < 300);
    arvalid = 0;
    if (!hs) fail("ar_timeout");
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input bit last);
    int n = 0; bit hs;
    wdata = d; wstrb = s; wlast = last; wvalid = 1;
    do begin @(negedge clk); hs = wready; @(posedge clk); #1; n++; end while (!hs && n < 300);
    wvalid = 0; wlast = 0;
    if (!hs) fail("w_timeout");
  endtask

  task automatic model_write(input logic [31:0] a, input int nbeats);
    int w = widx(a);
    for (int i = 0; i < nbeats; i++) begin
      ref_mem[w] = merge(ref_mem[w], wd[i], ws[i]);
      w = (w + 1) % DEPTH;
    end
  endtask

  task automatic drive_write(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                             input int nbeats);
    aw_send(id, a, len);
    for (int i = 0; i < nbeats; i++) w_beat(wd[i], ws[i], i == nbeats - 1);
  endtask

  task automatic write_issue(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                             input int nbeats);
    model_write(a, nbeats);
    b_q.push_back(id);
    drive_write(id, a, len, nbeats);
  endtask

  task automatic expect_read(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len);
    int w = widx(a);
    for (int i = 0; i <= int'(len); i++) begin
      rexp_t e;
      e.id = id; e.data = ref_mem[w]; e.last = (i == int'(len));
      r_q.push_back(e);
      w = (w + 1) % DEPTH;
    end
  endtask

  task automatic read_issue(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len);
    expect_read(id, a, len);
    ar_send(id, a, len);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) begin
      fail(name);
      b_q.delete();
      r_q.delete();
    end
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra, last_wa;
  logic [3:0]  rl;
  logic [7:0]  rid_r;
  int          start, n, rs0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end

    // Reset state
    wait_cycles(3);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_sram_cs", 32'(sram_cs), 32'd0);
    chk("rst_sram_web", 32'(sram_web), 32'hF);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    chk("idle_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;

    // Single write then single read
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    write_issue(8'h11, BASE + 32'h10, 4'd0, 1);
    wait_drain("drain_single_wr");
    read_issue(8'h12, BASE + 32'h10, 4'd0);
    wait_drain("drain_single_rd");
    chk("single_rdata", last_rdata, 32'hDEAD_BEEF);

    // 4-beat burst, beats every 2 cycles with rready high
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    write_issue(8'h21, BASE, 4'd3, 4);
    wait_drain("drain_burst_wr");
    r_cyc_log.delete();
    read_issue(8'h22, BASE, 4'd3);
    wait_drain("drain_burst_rd");
    chk("burst_beats", 32'(r_cyc_log.size()), 32'd4);
    for (int i = 1; i < r_cyc_log.size(); i++)
      chk("burst_beat_spacing", 32'(r_cyc_log[i] - r_cyc_log[i-1]), 32'd2);

    // Partial-strobe write over all-ones
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    write_issue(8'h31, BASE + 32'h20, 4'd0, 1);
    wd[0] = 32'h0000_5555; ws[0] = 4'b0011;
    write_issue(8'h32, BASE + 32'h20, 4'd0, 1);
    wait_drain("drain_partial_wr");
    read_issue(8'h33, BASE + 32'h20, 4'd0);
    wait_drain("drain_partial_rd");
    chk("partial_rdata", last_rdata, 32'hFFFF_5555);

    // Simultaneous AW and AR: write wins, read follows the B handshake
    wd[0] = 32'hA5A5_0001; ws[0] = 4'hF;
    model_write(BASE + 32'h40, 1);
    b_q.push_back(8'h41);
    expect_read(8'h42, BASE + 32'h40, 4'd0);
    fork
      drive_write(8'h41, BASE + 32'h40, 4'd0, 1);
      ar_send(8'h42, BASE + 32'h40, 4'd0);
    join
    wait_drain("drain_simul");
    chk("read_after_b", 32'(ar_cyc > b_cyc), 32'd1);
    chk("simul_rdata", last_rdata, 32'hA5A5_0001);

    // rready low for 5 cycles during beat 2
    rs0 = n_rstall;
    start = r_seen;
    fork
      read_issue(8'h51, BASE, 4'd3);
      begin
        n = 0;
        while (r_seen < start + 1 && n < 200) begin @(posedge clk); #1; n++; end
        rready = 0;
        wait_cycles(5);
        rready = 1;
      end
    join
    wait_drain("drain_rstall");
    chk("rstall_seen", 32'(n_rstall - rs0 >= 4), 32'd1);

    // bready low for 3 cycles
    bready = 0;
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    fork
      write_issue(8'h61, BASE + 32'h80, 4'd0, 1);
      begin
        n = 0;
        while (!bvalid && n < 200) begin @(posedge clk); #1; n++; end
        wait_cycles(3);
        bready = 1;
      end
    join
    wait_drain("drain_bstall");

    // Early wlast ends the burst before awlen is reached
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hE000_0000 + 32'(i); ws[i] = 4'hF; end
    write_issue(8'h71, BASE + 32'h100, 4'd7, 2);
    wait_drain("drain_early_wr");
    read_issue(8'h72, BASE + 32'h100, 4'd3);
    wait_drain("drain_early_rd");

    // Burst wrapping past the last SRAM word
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i); ws[i] = 4'hF; end
    write_issue(8'h81, BASE + 32'((DEPTH - 2) * 4), 4'd3, 4);
    wait_drain("drain_wrap_wr");
    read_issue(8'h82, BASE + 32'((DEPTH - 2) * 4), 4'd3);
    read_issue(8'h83, BASE, 4'd0);
    wait_drain("drain_wrap_rd");
    chk("wrap_word0", last_rdata, 32'hC0DE_0002);

    // Randomized traffic with backpressure
    bp_en = 1;
    last_wa = BASE;
    for (int t = 0; t < 40; t++) begin
      ra = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      if (t % 5 == 0) ra = BASE + 32'(4 * (DEPTH - 1 - $urandom_range(0, 3)));
      rl = 4'($urandom_range(0, 15));
      rid_r = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(rl); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        write_issue(rid_r, ra, rl, int'(rl) + 1);
        last_wa = ra;
      end else begin
        read_issue(rid_r, ($urandom_range(0, 1) == 1) ? last_wa : ra, rl);
      end
      wait_drain("drain_random");
    end
    bp_en = 0;
    @(posedge clk); #1;
    rready = 1; bready = 1;

    // Reset in the middle of a read burst
    start = r_seen;
    read_issue(8'h91, BASE, 4'd7);
    n = 0;
    while (r_seen < start + 2 && n < 200) begin @(posedge clk); #1; n++; end
    rstn = 0;
    @(posedge clk); #1;
    r_q.delete();
    @(negedge clk);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_sram_cs", 32'(sram_cs), 32'd0);
    chk("midrst_web", 32'(sram_web), 32'hF);
    @(posedge clk); #1;
    rstn = 1;
    wait_cycles(6);
    read_issue(8'h92, BASE + 32'h10, 4'd1);
    wait_drain("drain_after_rst");
    chk("after_rst_rdata", last_rdata, ref_mem[widx(BASE + 32'h14)]);

    wait_cycles(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
- REQ-001 SHALL have parameter ADDR_WORDS_BITS, default 14: SRAM word-address width (16K x 32b).
- REQ-002 SHALL have parameter BASE_ADDR, default 32'h0001_0000: AXI byte address mapped to SRAM word 0.
- REQ-003 clk  input  1  sole clock, all logic rising-edge.
- REQ-004 rstn  input  1  reset, synchronous, active-low.
- REQ-005 AW channel: awid in 8, awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
- REQ-006 W channel: wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
- REQ-007 B channel: bid out 8, bresp out 2, bvalid out 1, bready in 1.
- REQ-008 AR channel: arid in 8, araddr in 32, arlen in 4, arsize in 3, arburst in 2, arvalid in 1, arready out 1.
- REQ-009 R channel: rid out 8, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
- REQ-010 SRAM port: sram_cs out 1, sram_oe out 1, sram_web out 4 (active-low byte enables), sram_a out ADDR_WORDS_BITS, sram_di out 32, sram_do in 32 (valid one cycle after cs+oe).

Function
- REQ-011 SHALL be an FSM with states IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP; one transaction in flight at a time.
- REQ-012 In IDLE, awready=1 and arready=1; on simultaneous awvalid and arvalid, SHALL accept write only (arready forced 0 that cycle).
- REQ-013 AW handshake: latch awid, word address (awaddr-BASE_ADDR)>>2, awlen; go WR_DATA.
- REQ-014 WR_DATA: wready=1; each W handshake drives sram_cs=1, sram_web=~wstrb, sram_a=addr, sram_di=wdata in the same cycle; address +1 after each beat.
- REQ-015 W beat with wlast=1 SHALL end the burst regardless of beat count; go WR_RESP.
- REQ-016 WR_RESP: bvalid=1, bid=latched id, bresp=2'b00; hold until bready, then IDLE.
- REQ-017 AR handshake: latch arid, word address, arlen, beat counter=0; go RD_ADDR.
- REQ-018 RD_ADDR: sram_cs=1, sram_oe=1, sram_web=4'hF, sram_a=addr; next cycle RD_DATA.
- REQ-019 RD_DATA: rdata registered from sram_do on entry and held stable while rvalid=1 and rready=0; rid=latched id, rresp=2'b00, rlast=(counter==arlen).
- REQ-020 First rvalid SHALL be exactly 2 cycles after the AR handshake cycle; successive beats every 2 cycles with rready held high.
- REQ-021 R handshake with rlast: IDLE; otherwise address+1, counter+1, RD_ADDR.
- REQ-022 Word address SHALL wrap modulo 2^ADDR_WORDS_BITS; awsize/arsize and burst type ignored, all bursts treated as INCR of 4-byte beats.
- REQ-023 Outside the states above, sram_cs=0, sram_oe=0, sram_web=4'hF; all valid/ready outputs 0 except per REQ-012.
- REQ-024 awvalid/arvalid arriving outside IDLE SHALL be stalled (ready=0), not dropped.

Reset
- REQ-025 rstn=0 at a clock edge SHALL force IDLE, clear all latched id/address/counter registers, and set all outputs to 0 except sram_web=4'hF.
- REQ-026 Reset mid-burst SHALL abandon the burst with no B or R response afterwards.

Structure
- REQ-027 AXI widths SHALL come from the shared AXI_define header; state enum and SRAM macros in package axi_sram_pkg.
- REQ-028 Single module; the SRAM macro is instantiated outside and connected via the SRAM port.

Verification
- REQ-029 Single write awaddr=BASE+0x10, wdata=32'hDEADBEEF, wstrb=4'hF, then read len=0 -> rdata=32'hDEADBEEF, rlast=1, bresp=rresp=0.
- REQ-030 Write 4-beat burst 1,2,3,4 at BASE, read arlen=3 -> beats 1,2,3,4, rlast only on beat 4, first rvalid 2 cycles after AR handshake.
- REQ-031 Partial write wstrb=4'b0011, data 32'h0000_5555 over 32'hFFFF_FFFF -> readback 32'hFFFF_5555.
- REQ-032 awvalid and arvalid asserted in the same cycle -> write accepted first, read accepted after B handshake.
- REQ-033 rready low 5 cycles during beat 2 -> rdata stable, no beat lost; bready low 3 cycles -> bvalid held.
- REQ-034 rstn=0 mid read burst -> rvalid=0 next cycle, FSM in IDLE, new AR accepted after reset release.
